median_result_packer: RTL
=========================

Name: median_result_packer

Overview:
Downstream stage of the filtering module. It consumes the 1-bit median results (write enable, x/y median address, data) and packs them, in raster order, into 8-bit words. The words go through a small FIFO to a byte-wide ready/valid sink, such as the output frame RAM writer or the UART transmitter. It checks that the result addresses arrive in strict raster sequence, pads and flushes the final partial byte when filtering ends, and reports completion.

Parameters:
IMAGE_WIDTH, 240, input image width in pixels
IMAGE_HEIGHT, 180, input image height in pixels
WINDOW_SIZE, 3, median window edge; output frame is OUT_W=IMAGE_WIDTH-WINDOW_SIZE+1 by OUT_H=IMAGE_HEIGHT-WINDOW_SIZE+1
FIFO_DEPTH, 4, number of packed-byte entries buffered toward the sink (power of two)
ADDR_WIDTH, 13, width of the byte address; must hold ceil(OUT_W*OUT_H/8)-1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse, begins a new frame (same pulse that starts the filter)
pix_we  in  1  median result valid this cycle
pix_x  in  8  x coordinate of result in output frame
pix_y  in  8  y coordinate of result in output frame
pix_data  in  1  median result bit
filter_done  in  1  filter has issued its last window; sampled as a level
out_valid  out  1  out_data/out_addr valid
out_ready  in  1  sink accepts when out_valid && out_ready
out_data  out  8  packed byte; pixel k of the byte sits in bit k (LSB = earliest pixel)
out_addr  out  ADDR_WIDTH  byte index within the output frame (0-based)
busy  out  1  high in PACK or FLUSH
done  out  1  frame fully drained; held until start or reset
seq_error  out  1  sticky: a result arrived with an unexpected coordinate
overflow  out  1  sticky: a completed byte was dropped because the FIFO was full

Behaviour:
- Reset: state IDLE. out_valid=0, out_data=0, out_addr=0, busy=0, done=0, seq_error=0, overflow=0. FIFO emptied. Bit counter, expected x/y and byte counter cleared.
- States:
  - IDLE -> PACK on start.
  - PACK -> FLUSH on the first cycle filter_done=1.
  - FLUSH -> DONE when the pad byte, if any, is pushed and the FIFO is empty.
  - DONE -> PACK on start.
- start in any state: clears FIFO, counters and sticky flags; next state PACK; done=0. reset has priority over start.
- PACK, on pix_we:
  - Shift register bit[bitcnt] <= pix_data; bitcnt increments mod 8.
  - Expected coordinate (ex,ey) advances in raster order: ex wraps at OUT_W-1 to 0, ey then increments.
  - If (pix_x,pix_y) != (ex,ey), set seq_error. The pixel is still packed and expected position still advances.
- Byte complete (bitcnt goes 7->0): the byte and its byte counter value are pushed into the FIFO in the next cycle. The byte counter then increments. Unused shift bits are cleared after each push.
- pix_we in IDLE or DONE: ignored, no flag change.
- pix_we and filter_done in the same cycle: the pixel is accepted first, then FLUSH is entered.
- FLUSH:
  - If bitcnt != 0, one pad byte (unfilled high bits = 0) is pushed.
  - If bitcnt == 0, no extra byte.
  - pix_we in FLUSH is ignored.
- FIFO and output:
  - out_data/out_addr come from a registered FIFO head.
  - out_valid rises the cycle after the push into an empty FIFO, so latency is 2 cycles from the 8th pix_we to out_valid.
  - Head is stable while out_valid && !out_ready.
  - Push when full with no pop that cycle: byte dropped, overflow set, byte counter still increments.
  - Simultaneous push and pop when full: both succeed.
- done: asserted the cycle state enters DONE. busy=0 in IDLE and DONE.
- Frame size with defaults: 238x178 = 42364 pixels, giving 5296 bytes (addr 0..5295). The last byte holds 4 valid bits.

Test Plan:
- Reset then start; pixels 1,0,1,1,0,0,0,1 at (0..7,0), out_ready=1 -> one byte out_data=0x8D, out_addr=0, out_valid 2 cycles after 8th pix_we; seq_error=0.
- Full 238x178 frame of alternating 1/0 bits, then filter_done -> 5296 bytes with addr 0..5295 in order. Every byte is 0x55, except the last, which is 0x05. done=1, busy=0.
- Hold out_ready=0 across 40 in-order pixels -> first 4 bytes buffered. 5th byte dropped, overflow=1. Release out_ready -> addr 0,1,2,3 emitted.
- Pixel at (5,0) when (1,0) expected -> seq_error=1 and stays set until start. Bit still packed at position 1.
- filter_done asserted after exactly 16 pixels -> 2 bytes out, no pad byte, done=1. Repeat with 19 pixels -> 3rd byte with addr 2, bits [7:3]=0.
- Assert reset mid-frame while out_valid=1 -> next cycle out_valid=0, busy=0, flags 0. A subsequent start and 8 pixels produce addr 0.

Source files
------------

// File: rtl/median_result_packer.sv
// median_result_packer
// Packs 1-bit median filter results, arriving in raster order, into bytes
// (earliest pixel in bit 0) and hands them to a byte-wide ready/valid sink
// through a small FIFO. It also checks the result coordinates against the
// expected raster sequence, pads the final partial byte at end of frame and
// reports completion.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 one-cycle pulse: clear everything and begin a frame
//   pix_we/x/y/data       median result strobe, its coordinate and its bit
//   filter_done           level: filter has issued its last window
//   out_valid/out_ready   byte handshake toward the sink
//   out_data, out_addr    packed byte and its byte index within the frame
//   busy                  high while packing or flushing
//   done                  frame fully drained; held until start or reset
//   seq_error             sticky: a result arrived at an unexpected coordinate
//   overflow              sticky: a completed byte was dropped (FIFO full)
module median_result_packer #(
  parameter int IMAGE_WIDTH  = 240,
  parameter int IMAGE_HEIGHT = 180,
  parameter int WINDOW_SIZE  = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_WIDTH   = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pix_we,
  input  logic [7:0]            pix_x,
  input  logic [7:0]            pix_y,
  input  logic                  pix_data,
  input  logic                  filter_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  seq_error,
  output logic                  overflow
);

  localparam int OUT_W = IMAGE_WIDTH - WINDOW_SIZE + 1;
  localparam int OUT_H = IMAGE_HEIGHT - WINDOW_SIZE + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] LAST_X = 8'(OUT_W - 1);
  localparam logic [7:0] LAST_Y = 8'(OUT_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_r, stateNext_s;
  logic [7:0]            shift_r, packed_s;
  logic [2:0]            bitCnt_r;
  logic [7:0]            expX_r, expY_r;
  logic                  pend_r;          // a completed byte waits to enter the FIFO
  logic [7:0]            pendByte_r;
  logic [ADDR_WIDTH-1:0] byteCnt_r;
  logic [7:0]            dataMem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] addrMem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rdPtr_r, wrPtr_r, rdPtrNext_s;
  logic [CNT_W-1:0]      count_r, countNext_s;
  logic                  accept_s, seqBad_s, padReq_s;
  logic                  pop_s, full_s, wrEn_s, drop_s;
  logic [7:0]            headData_s;
  logic [ADDR_WIDTH-1:0] headAddr_s;

  // Next-state decode; start overrides the current state.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE:  stateNext_s = IDLE;
      PACK:  if (filter_done) stateNext_s = FLUSH; else stateNext_s = PACK;
      FLUSH: begin
        // Done once any pad byte has been pushed and the FIFO has drained.
        if (bitCnt_r == 3'd0 && !pend_r && count_r == CNT_W'(0)) stateNext_s = DONE;
        else stateNext_s = FLUSH;
      end
      DONE:  stateNext_s = DONE;
      default: stateNext_s = IDLE;
    endcase
    if (start) stateNext_s = PACK;
    else stateNext_s = stateNext_s;
  end

  // Pixel acceptance, sequence check, pad request and the packed byte image.
  always_comb begin
    accept_s = (state_r == PACK) && pix_we && !start;
    seqBad_s = accept_s && ((pix_x != expX_r) || (pix_y != expY_r));
    padReq_s = (state_r == FLUSH) && (bitCnt_r != 3'd0) && !start;
    packed_s = shift_r;
    packed_s[bitCnt_r] = pix_data;
  end

  // FIFO control and the next registered head.
  always_comb begin
    pop_s       = out_valid && out_ready;
    full_s      = (count_r == CNT_W'(FIFO_DEPTH));
    wrEn_s      = pend_r && (!full_s || pop_s);
    drop_s      = pend_r && full_s && !pop_s;
    rdPtrNext_s = pop_s ? rdPtr_r + PTR_W'(1) : rdPtr_r;
    countNext_s = count_r + CNT_W'(wrEn_s) - CNT_W'(pop_s);
    headData_s  = out_data;
    headAddr_s  = out_addr;
    if (countNext_s == CNT_W'(0)) begin
      headData_s = out_data;
      headAddr_s = out_addr;
    end else if (wrEn_s && (count_r == CNT_W'(pop_s))) begin
      // FIFO would otherwise be empty: the byte being written becomes the head.
      headData_s = pendByte_r;
      headAddr_s = byteCnt_r;
    end else begin
      headData_s = dataMem_r[rdPtrNext_s];
      headAddr_s = addrMem_r[rdPtrNext_s];
    end
  end

  // State register with registered busy/done status.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      busy    <= (stateNext_s == PACK) || (stateNext_s == FLUSH);
      done    <= (stateNext_s == DONE);
    end
  end

  // Packing datapath, raster tracking, byte counter, FIFO pointers and outputs.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      shift_r    <= 8'h00;
      bitCnt_r   <= 3'd0;
      expX_r     <= 8'd0;
      expY_r     <= 8'd0;
      pend_r     <= 1'b0;
      pendByte_r <= 8'h00;
      byteCnt_r  <= '0;
      seq_error  <= 1'b0;
      overflow   <= 1'b0;
      rdPtr_r    <= '0;
      wrPtr_r    <= '0;
      count_r    <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_addr   <= '0;
    end else begin
      if (accept_s) begin
        if (bitCnt_r == 3'd7) begin
          pendByte_r <= packed_s;
          pend_r     <= 1'b1;
          shift_r    <= 8'h00;
        end else begin
          shift_r <= packed_s;
          pend_r  <= 1'b0;
        end
        bitCnt_r <= bitCnt_r + 3'd1;
        if (expX_r == LAST_X) begin
          expX_r <= 8'd0;
          expY_r <= (expY_r == LAST_Y) ? 8'd0 : expY_r + 8'd1;
        end else begin
          expX_r <= expX_r + 8'd1;
        end
        if (seqBad_s) seq_error <= 1'b1;
      end else if (padReq_s) begin
        // High bits of the partial byte are already zero in the shift register.
        pendByte_r <= shift_r;
        pend_r     <= 1'b1;
        shift_r    <= 8'h00;
        bitCnt_r   <= 3'd0;
      end else begin
        pend_r <= 1'b0;
      end
      // The byte index advances even when the byte is dropped.
      if (pend_r) byteCnt_r <= byteCnt_r + ADDR_WIDTH'(1);
      if (drop_s) overflow <= 1'b1;
      if (wrEn_s) wrPtr_r <= wrPtr_r + PTR_W'(1);
      rdPtr_r   <= rdPtrNext_s;
      count_r   <= countNext_s;
      out_valid <= (countNext_s != CNT_W'(0));
      out_data  <= headData_s;
      out_addr  <= headAddr_s;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wrEn_s) begin
      dataMem_r[wrPtr_r] <= pendByte_r;
      addrMem_r[wrPtr_r] <= byteCnt_r;
    end
  end

endmodule
